// File: rtl/mcp_bus_resp.sv
// Bus responder for the chipset's asynchronous system bus (SYN/DI/DO/WRBY/INRAK/RA).
// Serves a word RAM window plus one CSR, and answers interrupt acknowledge with a fixed vector.
module mcp_bus_resp #(
  parameter logic [15:0] BASE     = 16'hE000,
  parameter int          RAM_AW   = 5,
  parameter logic [15:0] CSR_ADDR = 16'hFF70,
  parameter logic [15:0] VECTOR   = 16'h00C0,
  parameter int          WAIT     = 2
) (
  input  logic        pin_clk,
  input  logic        pin_sr_n,
  input  logic [15:0] pin_ad_in,
  output logic [15:0] pin_ad_out,
  output logic        pin_ad_oe,
  input  logic        pin_syn,
  input  logic        pin_di,
  input  logic        pin_do,
  input  logic        pin_wrby,
  input  logic        pin_inrak,
  output logic        pin_ra,
  output logic        pin_inrrq
);

  localparam int          WIN_BYTES = 2 * (2 ** RAM_AW);
  localparam logic [16:0] WIN_LO    = {1'b0, BASE};
  localparam logic [16:0] WIN_HI    = WIN_LO + 17'(WIN_BYTES);

  typedef enum logic [2:0] {S_IDLE, S_ADDR, S_WAIT, S_REPLY, S_DONE, S_IAK} state_t;

  state_t            state_q, state_d;
  logic              syn_q;
  logic [15:0]       addr_q, addr_d;
  logic              csr_sel_q, csr_sel_d;
  logic              rd_q, rd_d;
  logic              wrby_q, wrby_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              ra_q, ra_d, oe_q, oe_d;
  logic [15:0]       dout_q, dout_d;
  logic [1:0]        csr_q, csr_d;   // {REQ, IE} = CSR[7:6]
  logic              irq_q;
  logic [15:0]       ram_q [0:(1<<RAM_AW)-1];

  logic              syn_rise, hit_ram, hit_csr, strobe_cur, go_reply, commit, iak_clr;
  logic [16:0]       in_byte;
  logic [RAM_AW-1:0] ram_idx;
  logic [15:0]       csr_word, rd_word, wdata;

  assign syn_rise = pin_syn & ~syn_q;
  assign in_byte  = {1'b0, pin_ad_in[15:1], 1'b0};
  assign hit_ram  = (in_byte >= WIN_LO) && (in_byte < WIN_HI);
  assign hit_csr  = (pin_ad_in[15:1] == CSR_ADDR[15:1]);
  assign ram_idx  = RAM_AW'((addr_q - BASE) >> 1);
  assign csr_word = {8'h00, csr_q, 6'h00};
  assign rd_word  = csr_sel_q ? csr_word : ram_q[ram_idx];
  assign strobe_cur = rd_q ? pin_di : pin_do;

  // Byte lane chosen by the latched address LSB; the other lane keeps its old value.
  always_comb begin
    wdata = pin_ad_in;
    if (wrby_q) begin
      if (addr_q[0]) wdata = {pin_ad_in[15:8], rd_word[7:0]};
      else           wdata = {rd_word[15:8], pin_ad_in[7:0]};
    end
  end

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    csr_sel_d = csr_sel_q;
    rd_d      = rd_q;
    wrby_d    = wrby_q;
    cnt_d     = cnt_q;
    ra_d      = ra_q;
    oe_d      = oe_q;
    dout_d    = dout_q;
    go_reply  = 1'b0;
    commit    = 1'b0;
    iak_clr   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (syn_rise) begin
          addr_d    = pin_ad_in;
          csr_sel_d = hit_csr;
          if (hit_ram || hit_csr) state_d = S_ADDR;
        end else if (!pin_syn && pin_di && pin_inrak && irq_q) begin
          state_d = S_IAK;
          cnt_d   = 4'(WAIT);
          iak_clr = 1'b1;
        end
      end
      // DONE re-arms on a fresh strobe within the same SYN (read-modify-write).
      S_ADDR, S_DONE: begin
        if (!pin_syn) state_d = S_IDLE;
        else if (pin_di || pin_do) begin
          rd_d   = pin_di;
          wrby_d = pin_wrby;
          cnt_d  = 4'(WAIT);
          if (WAIT == 0) go_reply = 1'b1;
          else           state_d  = S_WAIT;
        end
      end
      S_WAIT: begin
        if (!pin_syn)         state_d  = S_IDLE;
        else if (!strobe_cur) state_d  = S_DONE;
        else if (cnt_q == '0) go_reply = 1'b1;
        else                  cnt_d    = cnt_q - 4'd1;
      end
      S_REPLY: begin
        if (!pin_syn || !strobe_cur) begin
          state_d = pin_syn ? S_DONE : S_IDLE;
          ra_d    = 1'b0;
          oe_d    = 1'b0;
        end
      end
      S_IAK: begin
        if (!pin_di) begin
          state_d = S_IDLE;
          ra_d    = 1'b0;
          oe_d    = 1'b0;
        end else if (!ra_q) begin
          if (cnt_q == '0) begin
            ra_d   = 1'b1;
            oe_d   = 1'b1;
            dout_d = VECTOR;
          end else cnt_d = cnt_q - 4'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
    // A write commits only on the edge entering REPLY, so an abort before then drops it.
    if (go_reply) begin
      state_d = S_REPLY;
      ra_d    = 1'b1;
      oe_d    = rd_d;
      if (rd_d) dout_d = rd_word;
      else      commit = 1'b1;
    end
  end

  always_comb begin
    csr_d = csr_q;
    if (commit && csr_sel_q) csr_d = {wdata[7], wdata[6]};
    if (iak_clr)             csr_d[1] = 1'b0;
  end

  always_ff @(posedge pin_clk or negedge pin_sr_n) begin
    if (!pin_sr_n) begin
      state_q   <= S_IDLE;
      syn_q     <= 1'b0;
      addr_q    <= '0;
      csr_sel_q <= 1'b0;
      rd_q      <= 1'b0;
      wrby_q    <= 1'b0;
      cnt_q     <= '0;
      ra_q      <= 1'b0;
      oe_q      <= 1'b0;
      dout_q    <= '0;
      csr_q     <= '0;
      irq_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      syn_q     <= pin_syn;
      addr_q    <= addr_d;
      csr_sel_q <= csr_sel_d;
      rd_q      <= rd_d;
      wrby_q    <= wrby_d;
      cnt_q     <= cnt_d;
      ra_q      <= ra_d;
      oe_q      <= oe_d;
      dout_q    <= dout_d;
      csr_q     <= csr_d;
      irq_q     <= csr_d[1] & csr_d[0];
    end
  end

  // RAM is not reset; a write coinciding with reset is suppressed.
  always_ff @(posedge pin_clk) begin
    if (commit && !csr_sel_q && pin_sr_n) ram_q[ram_idx] <= wdata;
  end

  assign pin_ad_out = dout_q;
  assign pin_ad_oe  = oe_q;
  assign pin_ra     = ra_q;
  assign pin_inrrq  = irq_q;

endmodule
